switch_output_reader: RTL

Read-side counterpart of the switch's Avalon-MM write path. Software pushes packets into the per-port input RAMs through the write path. This block captures the words the scheduler/megamux deliver on each output port into per-port FIFOs. Software drains them through Avalon-MM reads, and the block reports per-port status and raises an interrupt when data is waiting.

---
 rtl/switch_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/switch_output_reader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared constants for the switch output reader.
// Register map, status bit offsets and sizing defaults.
package switch_pkg;

  localparam int NUM_PORTS = 3;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16;
  localparam int AV_W      = 32;
  localparam int ADDR_W    = 4;

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_DATA0    = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT0   = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 4'h7;

  localparam int STAT_NE_OFS   = 0;
  localparam int STAT_FULL_OFS = 8;
  localparam int STAT_OVF_OFS  = 16;
  localparam int STAT_UDF_OFS  = 24;

  // Per-port register address: base + port index.
  function automatic logic [ADDR_W-1:0] port_addr(
    input logic [ADDR_W-1:0] base,
    input int                idx
  );
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head word.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/switch_output_reader.sv
// Captures switch output words into per-port FIFOs and
// exposes them to software over an Avalon-MM slave.
module switch_output_reader #(
  parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
  parameter int DATA_W    = switch_pkg::DATA_W,
  parameter int DEPTH     = switch_pkg::DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] out_data,
  input  logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS-1:0]        out_ready,
  input  logic                        chipselect,
  input  logic                        read,
  input  logic                        write,
  input  logic [3:0]                  address,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq
);

  import switch_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_sel_data;
  logic [NUM_PORTS-1:0] w_sel_cnt;
  logic [NUM_PORTS-1:0] w_ovf_set;
  logic [NUM_PORTS-1:0] w_udf_set;
  logic [NUM_PORTS-1:0] w_ovf_clr;
  logic [NUM_PORTS-1:0] w_udf_clr;
  logic [DATA_W-1:0]    w_head [NUM_PORTS];
  logic [CW-1:0]        w_count [NUM_PORTS];
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_w1c;
  logic [31:0]          w_status;
  logic [31:0]          w_rdata;

  logic [NUM_PORTS-1:0] r_ovf;
  logic [NUM_PORTS-1:0] r_udf;
  logic [NUM_PORTS-1:0] r_mask;
  logic [31:0]          r_rdata;
  logic                 r_irq;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_push[g]     = out_valid[g] && out_ready[g];
    assign w_sel_data[g] = (address == port_addr(ADDR_DATA0, g));
    assign w_sel_cnt[g]  = (address == port_addr(ADDR_COUNT0, g));

    sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .i_rst_n (reset),
      .i_push  (w_push[g]),
      .i_wdata (out_data[g*DATA_W +: DATA_W]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g])
    );
  end

  // Ready reflects registered fullness, so a pop on a full
  // FIFO cannot admit a new word in the same cycle.
  assign out_ready = {NUM_PORTS{reset}} & ~w_full;

  // A read wins over a simultaneous write.
  assign w_rd  = chipselect && read;
  assign w_wr  = chipselect && write && !read;
  assign w_w1c = w_wr && (address == ADDR_STATUS);

  assign w_pop     = {NUM_PORTS{w_rd}} & w_sel_data & ~w_empty;
  assign w_udf_set = {NUM_PORTS{w_rd}} & w_sel_data & w_empty;
  assign w_ovf_set = out_valid & w_full;
  assign w_ovf_clr = {NUM_PORTS{w_w1c}}
                   & writedata[STAT_OVF_OFS +: NUM_PORTS];
  assign w_udf_clr = {NUM_PORTS{w_w1c}}
                   & writedata[STAT_UDF_OFS +: NUM_PORTS];

  // Assemble the STATUS word from live FIFO flags and stickies.
  always_comb begin
    w_status = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_status[STAT_NE_OFS + i]   = !w_empty[i];
      w_status[STAT_FULL_OFS + i] = w_full[i];
      w_status[STAT_OVF_OFS + i]  = r_ovf[i];
      w_status[STAT_UDF_OFS + i]  = r_udf[i];
    end
  end

  // Read data mux; an empty DATA port and unmapped addresses give 0.
  always_comb begin
    w_rdata = '0;
    unique case (address)
      ADDR_STATUS:   w_rdata = w_status;
      ADDR_IRQ_MASK: w_rdata = 32'(r_mask);
      default: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (w_sel_data[i] && !w_empty[i])
            w_rdata = 32'(w_head[i]);
          if (w_sel_cnt[i])
            w_rdata = 32'(w_count[i]);
        end
      end
    endcase
  end

  // Sticky overflow/underflow; a new event beats a W1C clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
      r_udf <= (r_udf & ~w_udf_clr) | w_udf_set;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (w_wr && (address == ADDR_IRQ_MASK)) begin
      r_mask <= writedata[NUM_PORTS-1:0];
    end
  end

  // Read data register; holds between reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

  // Level interrupt from masked nonempty or any overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((~w_empty & r_mask) | r_ovf);
    end
  end

  assign readdata = r_rdata;
  assign irq      = r_irq;

endmodule
